// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: redirect from decode, instruction-memory request/response, decode-side head entry.
// Handshake: a transfer happens on a rising clk edge with valid && ready both 1; until then the sender
// holds valid and payload stable (a redirect may move mem_req_addr). mem_rsp_valid has no ready: always taken.
interface inst_fetch_queue_if #(parameter int PC_W = 8);
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            mem_req_valid;
  logic [PC_W-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            dec_valid;
  logic [31:0]     dec_inst;
  logic [PC_W-1:0] dec_pc;
  logic            dec_ready;

  modport master (
    input  redirect, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, dec_ready,
    output mem_req_valid, mem_req_addr, dec_valid, dec_inst, dec_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, dec_ready,
    input  mem_req_valid, mem_req_addr, dec_valid, dec_inst, dec_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: credit-limited fetch requests, in-order responses into a FIFO, redirect flush/drain.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  inst_fetch_queue_if.master       bus,
  output logic                     dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count,
  output logic [$clog2(DEPTH):0]   dbg_outstanding,
  output logic [$clog2(DEPTH):0]   dbg_discard
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic {ST_FETCH = 1'b0, ST_DRAIN = 1'b1} state_t;
  state_t state, state_nxt;

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, outstanding, discard_cnt, out_nxt;
  logic [PC_W-1:0] fetch_pc, rsp_pc;
  logic [CW:0]     occupancy;
  logic            fifo_nonempty, req_fire, rsp_accept, rsp_drop;
  logic            byp_active, byp_take, push, pop;

  assign occupancy     = {1'b0, count} + {1'b0, outstanding};
  assign fifo_nonempty = (count != '0);
  assign req_fire      = bus.mem_req_valid & bus.mem_req_ready;
  // Outstanding after this cycle's request and response; also the drain length on a redirect.
  assign out_nxt       = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);

`ifdef IFQ_BYPASS_EN
  assign byp_active = ~rst & rsp_accept & ~fifo_nonempty;
`else
  assign byp_active = 1'b0;
`endif
  assign byp_take = byp_active & bus.dec_ready;
  assign push     = rsp_accept & ~byp_take;
  assign pop      = fifo_nonempty & bus.dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect)
      state_nxt = (out_nxt != '0) ? ST_DRAIN : ST_FETCH;
    else if (state == ST_DRAIN && bus.mem_rsp_valid && discard_cnt == CW'(1))
      state_nxt = ST_FETCH;
  end

  always_comb begin
    bus.mem_req_valid = 1'b0;
    rsp_accept        = 1'b0;
    rsp_drop          = 1'b0;
    case (state)
      ST_FETCH: begin
        bus.mem_req_valid = ~rst & (occupancy < DEPTH_C);
        rsp_accept        = bus.mem_rsp_valid & ~bus.redirect;
      end
      ST_DRAIN: rsp_drop = bus.mem_rsp_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      fetch_pc    <= '0;
      rsp_pc      <= '0;
    end else begin
      outstanding <= out_nxt;
      if (bus.redirect) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        discard_cnt <= out_nxt;
        fetch_pc    <= bus.redirect_pc;
        rsp_pc      <= bus.redirect_pc;
      end else begin
        if (req_fire)   fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_accept) rsp_pc   <= rsp_pc + PC_STEP;
        if (push)       wr_ptr   <= wr_ptr + AW'(1);
        if (pop)        rd_ptr   <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (rsp_drop && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.mem_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

  // Empty FIFO shows zeros so the decode bus is clean when nothing is valid.
  always_comb begin
    bus.dec_valid = fifo_nonempty;
    bus.dec_inst  = fifo_nonempty ? inst_mem[rd_ptr] : 32'h0;
    bus.dec_pc    = fifo_nonempty ? pc_mem[rd_ptr] : '0;
    if (byp_active) begin
      bus.dec_valid = 1'b1;
      bus.dec_inst  = bus.mem_rsp_data;
      bus.dec_pc    = rsp_pc;
    end
  end

  assign bus.mem_req_addr    = fetch_pc;
  assign dbg_state           = state;
  assign dbg_count           = count;
  assign dbg_outstanding     = outstanding;
  assign dbg_discard         = discard_cnt;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: memory model with stale tagging, scoreboard of expected decode entries,
// table of streaming/stall phases, then redirect, wrap, redirect+pop, bypass and mid-run reset sequences.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 8;
  localparam int W     = PC_W + 32;

`ifdef IFQ_BYPASS_EN
  localparam int R0_POPS = 9, R0_CNT = 0, R1_REQS = 3;
`else
  localparam int R0_POPS = 8, R0_CNT = 1, R1_REQS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       dbg_state;
  logic [2:0] dbg_count, dbg_outstanding, dbg_discard;

  inst_fetch_queue_if #(.PC_W(PC_W)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .dbg_state       (dbg_state),
    .dbg_count       (dbg_count),
    .dbg_outstanding (dbg_outstanding),
    .dbg_discard     (dbg_discard)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed { logic [PC_W-1:0] addr; logic stale; } pend_t;

  typedef struct {
    int cycles;
    bit req_ready;
    bit dec_rdy;
    bit rsp_on;
    int exp_reqs;
    int exp_pops;
    int exp_count;
    int exp_out;
  } row_t;

  pend_t           pend_q[$];
  logic [W-1:0]    exp_q[$];
  logic [PC_W-1:0] exp_fetch_pc;
  bit              rsp_en;
  int              n_checks, n_errors, n_reqs, n_pops;
  bit              seen_fire, seen_pop, cyc_rsp, cyc_pop;
  bit              have_prev_pop, have_prev_fire, wrap_pop, wrap_fire;
  logic [PC_W-1:0] first_fire_addr, first_pop_pc, prev_pop_pc, prev_fire_addr;
  logic [31:0]     last_pop_inst;
  row_t            tbl[5];

  function automatic logic [31:0] mem_fn(input logic [PC_W-1:0] a);
    if (a == 8'h80) return 32'h00500093;
    return {8'h13, a, ~a, 8'h5A};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock cycle: drive the memory response, sample at negedge, update model, return at posedge+1.
  task automatic step();
    bit              any_stale, live, exp_dv, fire, popd;
    int              occ;
    pend_t           r;
    logic [W-1:0]    e;
    logic [PC_W-1:0] issued;
    if (rsp_en && pend_q.size() > 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = mem_fn(pend_q[0].addr);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = 32'h0;
    end
    @(negedge clk);
    any_stale = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].stale) any_stale = 1'b1;
    occ = exp_q.size() + pend_q.size();
    check("req_valid", bus.mem_req_valid, (!any_stale && occ < DEPTH));
    if (bus.mem_req_valid) check("req_addr", bus.mem_req_addr, exp_fetch_pc);
    live    = 1'b0;
    cyc_rsp = bus.mem_rsp_valid;
    if (bus.mem_rsp_valid) begin
      r    = pend_q.pop_front();
      live = !r.stale && !bus.redirect;
    end
    exp_dv = (exp_q.size() != 0);
`ifdef IFQ_BYPASS_EN
    if (live) exp_dv = 1'b1;
`endif
    check("dec_valid", bus.dec_valid, exp_dv);
    if (live) exp_q.push_back({r.addr, mem_fn(r.addr)});
    popd    = bus.dec_valid && bus.dec_ready;
    cyc_pop = popd;
    if (popd) begin
      check("dec_has_entry", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dec_pc", bus.dec_pc, e[W-1:32]);
        check("dec_inst", bus.dec_inst, e[31:0]);
      end
      n_pops++;
      if (have_prev_pop && prev_pop_pc == 8'hFC && bus.dec_pc == 8'h00) wrap_pop = 1'b1;
      if (!seen_pop) first_pop_pc = bus.dec_pc;
      seen_pop      = 1'b1;
      have_prev_pop = 1'b1;
      prev_pop_pc   = bus.dec_pc;
      last_pop_inst = bus.dec_inst;
    end
    fire = bus.mem_req_valid && bus.mem_req_ready;
    if (fire) begin
      issued = exp_fetch_pc;
      pend_q.push_back({issued, 1'b0});
      n_reqs++;
      if (have_prev_fire && prev_fire_addr == 8'hFC && bus.mem_req_addr == 8'h00) wrap_fire = 1'b1;
      if (!seen_fire) first_fire_addr = bus.mem_req_addr;
      seen_fire      = 1'b1;
      have_prev_fire = 1'b1;
      prev_fire_addr = bus.mem_req_addr;
      exp_fetch_pc   = exp_fetch_pc + 8'd4;
    end
    if (bus.redirect) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_fetch_pc = bus.redirect_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_pc   = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    bus.mem_req_ready = 1'b1;
    bus.dec_ready     = 1'b1;
    @(negedge clk);
    check("rst_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_req_addr", bus.mem_req_addr, 8'h00);
    check("rst_dec_valid", bus.dec_valid, 1'b0);
    check("rst_dec_inst", bus.dec_inst, 32'h0);
    check("rst_dec_pc", bus.dec_pc, 8'h00);
    check("rst_state", dbg_state, 1'b0);
    check("rst_count", dbg_count, 3'd0);
    check("rst_outstanding", dbg_outstanding, 3'd0);
    check("rst_discard", dbg_discard, 3'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_req_valid", bus.mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_fetch_pc = '0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_reqs = 0; n_pops = 0;
    seen_fire = 0; seen_pop = 0; have_prev_pop = 0; have_prev_fire = 0;
    wrap_pop = 0; wrap_fire = 0; rsp_en = 1'b1;
    first_fire_addr = '0; first_pop_pc = '0; prev_pop_pc = '0; prev_fire_addr = '0;
    last_pop_inst = '0;
    do_reset();

    //          cycles rdy  dec  rsp  reqs     pops     count   out
    tbl[0] = '{10,    1'b1, 1'b1, 1'b1, 10,      R0_POPS, R0_CNT, 1};
    tbl[1] = '{10,    1'b1, 1'b0, 1'b1, R1_REQS, 0,       4,      0};
    tbl[2] = '{6,     1'b1, 1'b1, 1'b1, 5,       6,       2,      1};
    tbl[3] = '{4,     1'b0, 1'b1, 1'b1, 0,       3,       0,      0};
    tbl[4] = '{3,     1'b1, 1'b1, 1'b0, 3,       0,       0,      3};
    for (int i = 0; i < 5; i++) begin
      bus.mem_req_ready = tbl[i].req_ready;
      bus.dec_ready     = tbl[i].dec_rdy;
      rsp_en            = tbl[i].rsp_on;
      n_reqs = 0;
      n_pops = 0;
      for (int c = 0; c < tbl[i].cycles; c++) step();
      check($sformatf("row%0d_reqs", i), n_reqs, tbl[i].exp_reqs);
      check($sformatf("row%0d_pops", i), n_pops, tbl[i].exp_pops);
      check($sformatf("row%0d_count", i), dbg_count, tbl[i].exp_count);
      check($sformatf("row%0d_outstanding", i), dbg_outstanding, tbl[i].exp_out);
    end

    // Redirect with three fetches in flight.
    bus.mem_req_ready = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_pc   = 8'h40;
    step();
    bus.redirect = 1'b0;
    check("a_state_drain", dbg_state, 1'b1);
    check("a_discard", dbg_discard, 3'd3);
    check("a_count", dbg_count, 3'd0);
    check("a_dec_valid_next", bus.dec_valid, 1'b0);
    rsp_en            = 1'b1;
    bus.mem_req_ready = 1'b1;
    seen_fire = 0;
    seen_pop  = 0;
    for (int c = 0; c < 12; c++) step();
    check("a_seen_fire", seen_fire, 1'b1);
    check("a_first_addr", first_fire_addr, 8'h40);
    check("a_seen_pop", seen_pop, 1'b1);
    check("a_first_dec_pc", first_pop_pc, 8'h40);

    // Address wrap through 0xFC.
    bus.redirect      = 1'b1;
    bus.redirect_pc   = 8'hF0;
    bus.mem_req_ready = 1'b0;
    step();
    bus.redirect      = 1'b0;
    bus.mem_req_ready = 1'b1;
    have_prev_pop  = 0;
    have_prev_fire = 0;
    wrap_pop       = 0;
    wrap_fire      = 0;
    for (int c = 0; c < 16; c++) step();
    check("b_wrap_fire", wrap_fire, 1'b1);
    check("b_wrap_pop", wrap_pop, 1'b1);

    // Redirect coinciding with a response and a pop.
    for (int c = 0; c < 4; c++) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    step();
    bus.redirect = 1'b0;
    check("c_rsp_in_cycle", cyc_rsp, 1'b1);
`ifndef IFQ_BYPASS_EN
    check("c_pop_in_cycle", cyc_pop, 1'b1);
`endif
    check("c_count_empty", dbg_count, 3'd0);
    check("c_discard", dbg_discard, 3'd1);
    check("c_state", dbg_state, 1'b1);
    for (int c = 0; c < 10; c++) step();

`ifdef IFQ_BYPASS_EN
    // Same-cycle bypass into an empty FIFO.
    bus.mem_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h80;
    step();
    bus.redirect      = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    seen_pop = 0;
    step();
    check("d_same_cycle_pop", cyc_pop, 1'b1);
    check("d_pc", first_pop_pc, 8'h80);
    check("d_inst", last_pop_inst, 32'h00500093);
    check("d_count", dbg_count, 3'd0);
    bus.mem_req_ready = 1'b1;
`endif

    // Reset in the middle of streaming.
    bus.mem_req_ready = 1'b1;
    bus.dec_ready     = 1'b1;
    for (int c = 0; c < 5; c++) step();
    do_reset();
    seen_fire = 0;
    step();
    check("e_seen_fire", seen_fire, 1'b1);
    check("e_first_addr", first_fire_addr, 8'h00);
    for (int c = 0; c < 8; c++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries and maximum outstanding fetches (power of two, 2..16).
REQ-002 The block SHALL have parameter PC_W, default 8, meaning byte-address width of the PC.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port redirect  input  1  branch/jump redirect from decode; flushes the queue.
REQ-006 Port redirect_pc  input  PC_W  new fetch address, valid when redirect=1.
REQ-007 Port mem_req_valid  output  1  fetch request to instruction memory.
REQ-008 Port mem_req_addr  output  PC_W  fetch address.
REQ-009 Port mem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 Port mem_rsp_valid  input  1  in-order instruction response, latency >= 1 cycle.
REQ-011 Port mem_rsp_data  input  32  fetched instruction word.
REQ-012 Port dec_valid  output  1  instruction available to the IF-ID register.
REQ-013 Port dec_inst  output  32  instruction word.
REQ-014 Port dec_pc  output  PC_W  address of dec_inst.
REQ-015 Port dec_ready  input  1  decode consumes the head entry (0 while the pipeline stalls).

Function
REQ-016 A request transfer SHALL occur when mem_req_valid and mem_req_ready are both 1; fetch_pc then advances by 4, modulo 2^PC_W (0xFC wraps to 0x00).
REQ-017 mem_req_valid SHALL be 1 only in FETCH state when (FIFO count + outstanding) < DEPTH.
REQ-018 mem_req_addr SHALL be held stable while mem_req_valid=1 and mem_req_ready=0, except on a redirect cycle.
REQ-019 An accepted response SHALL be written to the FIFO tail, tagged with rsp_pc; rsp_pc then advances by 4 with the same wrap rule.
REQ-020 dec_valid SHALL equal (FIFO not empty); dec_inst/dec_pc SHALL show the head entry; a pop SHALL occur when dec_valid and dec_ready are both 1.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged. The FIFO SHALL never overflow, because of the credit rule in REQ-017.
REQ-022 The outstanding counter SHALL increment on a request transfer and decrement on a response, and SHALL be unchanged when both occur.
REQ-023 FSM states SHALL be FETCH and DRAIN.
REQ-024 On redirect=1 in any state, the block SHALL:
  - empty the FIFO;
  - load fetch_pc and rsp_pc with redirect_pc;
  - load discard_cnt with the outstanding count after this cycle's request/response;
  - go to DRAIN if that count is nonzero, else to FETCH.
REQ-025 In DRAIN, no requests SHALL be issued; each response SHALL be dropped and decrement discard_cnt; the FSM SHALL return to FETCH on the cycle discard_cnt reaches 0.
REQ-026 A response coinciding with redirect SHALL be discarded. A pop coinciding with redirect SHALL still count as consumed, and the queue SHALL then be empty.
REQ-027 A request transfer coinciding with redirect SHALL be counted as outstanding and later discarded.
REQ-028 Latency from response to dec_valid SHALL be 1 cycle (registered FIFO), except as given in Configuration.

Reset
REQ-029 While rst=1, the block SHALL hold:
  - state FETCH; FIFO empty; outstanding and discard_cnt 0;
  - fetch_pc and rsp_pc 0;
  - mem_req_valid 0, mem_req_addr 0;
  - dec_valid 0, dec_inst 0x00000000, dec_pc 0.
REQ-030 The first request (addr 0x00) SHALL be presented in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-operation SHALL abandon all outstanding fetches without waiting for their responses.

Configuration
REQ-032 With macro IFQ_BYPASS_EN defined: when the FIFO is empty, state is FETCH, redirect=0 and mem_rsp_valid=1, the block SHALL drive dec_valid=1 with dec_inst=mem_rsp_data and dec_pc=rsp_pc combinationally in the same cycle; if dec_ready=1 the entry SHALL NOT be written to the FIFO.
REQ-033 Without IFQ_BYPASS_EN, the block SHALL have no combinational path from mem_rsp_* to dec_*, and response-to-dec_valid latency SHALL be exactly 1 cycle.

Verification
REQ-034 Reset release, mem_req_ready=1, 1-cycle response latency, dec_ready=1 -> addresses 0x00,0x04,0x08... in consecutive cycles; dec_pc follows the same sequence with no gaps.
REQ-035 dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0; count reaches 4; no data lost when dec_ready returns to 1.
REQ-036 3 fetches outstanding, redirect with redirect_pc=0x40 -> dec_valid=0 next cycle; the 3 stale responses are dropped; next request addr is 0x40; first dec_pc is 0x40.
REQ-037 Fetch through 0xFC -> next address 0x00; dec_pc 0xFC followed by 0x00.
REQ-038 Redirect on the same cycle as a response and a pop -> response dropped, queue empty, discard_cnt equals the remaining outstanding count.
REQ-039 IFQ_BYPASS_EN defined, FIFO empty, response 0x00500093 with dec_ready=1 -> dec_valid=1 and dec_inst=0x00500093 in the same cycle; count stays 0.
